// File: rtl/led_message_scroller.sv
// -----------------------------------------------------------------------------
// led_message_scroller
//
// Feeds the 4-digit multiplexed 7-segment driver. A 16-entry message of 4-bit
// display codes (0-9 digits, 10 dash, 11 F, 12 blank) is shown through a
// 4-code window that slides one entry per advance. An advance comes from a
// debounced push-button press or from a periodic scroll tick when auto_en
// is high. The window start wraps 15 -> 0, and so do the window indices.
//
// Ports
//   clk        system clock
//   reset      synchronous, active-high reset
//   step_btn   raw asynchronous push-button, 1 = pressed
//   auto_en    1 = timed scrolling enabled
//   load_en    1 = write load_data into message[load_addr] this edge
//   load_addr  message entry index 0..15
//   load_data  display code to store (13-15 are stored unchanged)
//   char3      message[pos]          (leftmost digit)
//   char2      message[pos+1 mod 16]
//   char1      message[pos+2 mod 16]
//   char0      message[pos+3 mod 16]
//   pos        current window start index
// -----------------------------------------------------------------------------
module led_message_scroller #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SCROLL_DIV      = 25000000,
  parameter int DIV_W           = 25
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       step_btn,
  input  logic       auto_en,
  input  logic       load_en,
  input  logic [3:0] load_addr,
  input  logic [3:0] load_data,
  output logic [3:0] char3,
  output logic [3:0] char2,
  output logic [3:0] char1,
  output logic [3:0] char0,
  output logic [3:0] pos
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCROLL_DIV - 1);

  typedef enum logic [1:0] {
    LOW_STABLE,
    WAIT_HIGH,
    HIGH_STABLE,
    WAIT_LOW
  } db_state_t;

  // ---------------------------------------------------------------------------
  // Button synchronizer: two flops before the raw level touches any logic.
  // ---------------------------------------------------------------------------
  logic btn_meta;
  logic btn_s;

  // NOTE: every clocked process uses non-blocking (<=) assignments so all
  // registers see the pre-edge values of each other, independent of order.
  always_ff @(posedge clk) begin
    if (reset) begin
      btn_meta <= 1'b0;
      btn_s    <= 1'b0;
    end else begin
      btn_meta <= step_btn;
      btn_s    <= btn_meta;
    end
  end

  // ---------------------------------------------------------------------------
  // Debounce FSM. A level change must hold for DEBOUNCE_CYCLES sampled cycles
  // before it is accepted; only the accepted low->high change emits step_pulse,
  // so a long hold or bounce on either edge gives exactly one step.
  // ---------------------------------------------------------------------------
  db_state_t       db_state, db_state_nxt;
  logic [DB_W-1:0] db_cnt,   db_cnt_nxt;
  logic            step_pulse;

  always_ff @(posedge clk) begin
    if (reset) begin
      db_state <= LOW_STABLE;
      db_cnt   <= '0;
    end else begin
      db_state <= db_state_nxt;
      db_cnt   <= db_cnt_nxt;
    end
  end

  // NOTE: every output of this block is given a default first, so no path
  // through the case leaves a signal unassigned and no latch is inferred.
  always_comb begin
    db_state_nxt = db_state;
    db_cnt_nxt   = db_cnt;
    step_pulse   = 1'b0;
    unique case (db_state)
      LOW_STABLE: begin
        if (btn_s) begin
          db_state_nxt = WAIT_HIGH;
          db_cnt_nxt   = '0;
        end
      end
      WAIT_HIGH: begin
        if (!btn_s) begin
          db_state_nxt = LOW_STABLE;
        end else if (db_cnt == DB_LAST) begin
          db_state_nxt = HIGH_STABLE;
          step_pulse   = 1'b1;
        end else begin
          db_cnt_nxt = db_cnt + 1'b1;
        end
      end
      HIGH_STABLE: begin
        if (!btn_s) begin
          db_state_nxt = WAIT_LOW;
          db_cnt_nxt   = '0;
        end
      end
      WAIT_LOW: begin
        if (btn_s) begin
          db_state_nxt = HIGH_STABLE;
        end else if (db_cnt == DB_LAST) begin
          db_state_nxt = LOW_STABLE;
        end else begin
          db_cnt_nxt = db_cnt + 1'b1;
        end
      end
      default: db_state_nxt = LOW_STABLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Auto-scroll timer. Held at zero while disabled, so re-enabling always
  // gives a full SCROLL_DIV period before the first tick.
  // ---------------------------------------------------------------------------
  logic [DIV_W-1:0] div_cnt;
  logic             tick;

  assign tick = auto_en && (div_cnt == DIV_LAST);

  always_ff @(posedge clk) begin
    if (reset || !auto_en) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Window position and message store. A simultaneous button step and timer
  // tick still move the window by one.
  // ---------------------------------------------------------------------------
  logic       advance;
  logic [3:0] message [16];

  assign advance = step_pulse | tick;

  // NOTE: the message is a small register file, not a RAM macro, so it can be
  // given reset values; reset restores the default 0..12 then blanks pattern.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) begin
        message[i] <= (i <= 12) ? 4'(i) : 4'd12;
      end
      pos <= '0;
    end else begin
      if (load_en) begin
        message[load_addr] <= load_data;
      end
      if (advance) begin
        pos <= pos + 4'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registered window outputs: sampled from the already-updated pos/message,
  // so a change at one edge becomes visible after the next. 4-bit index
  // arithmetic gives the mod-16 wrap for free.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      char3 <= 4'd0;
      char2 <= 4'd1;
      char1 <= 4'd2;
      char0 <= 4'd3;
    end else begin
      char3 <= message[pos];
      char2 <= message[pos + 4'd1];
      char1 <= message[pos + 4'd2];
      char0 <= message[pos + 4'd3];
    end
  end

endmodule

// File: tb/tb_led_message_scroller.sv
// -----------------------------------------------------------------------------
// tb_led_message_scroller
//
// Directed bench for led_message_scroller with DEBOUNCE_CYCLES=8 and
// SCROLL_DIV=4. Inputs change 1 time unit after a rising edge and outputs
// are examined at that same point, well clear of the next edge.
// Button-to-pos latency with these settings: pos moves at the 11th edge after
// the button goes high, the chars at the 12th.
// -----------------------------------------------------------------------------
module tb_led_message_scroller;

  logic       clk = 1'b0;
  logic       reset;
  logic       step_btn;
  logic       auto_en;
  logic       load_en;
  logic [3:0] load_addr;
  logic [3:0] load_data;
  logic [3:0] char3, char2, char1, char0;
  logic [3:0] pos;

  int total = 0;
  int bad   = 0;

  led_message_scroller #(
    .DEBOUNCE_CYCLES(8),
    .SCROLL_DIV     (4),
    .DIV_W          (3)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .step_btn (step_btn),
    .auto_en  (auto_en),
    .load_en  (load_en),
    .load_addr(load_addr),
    .load_data(load_data),
    .char3    (char3),
    .char2    (char2),
    .char1    (char1),
    .char0    (char0),
    .pos      (pos)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] chars();
    return {char3, char2, char1, char0};
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1);
    reset = 1'b0;
  endtask

  // 1: reset held two cycles, then idle inputs must not move the window.
  task automatic test_reset();
    reset = 1'b1;
    step(2);
    total++;
    if (chars() !== 16'h0123) begin
      bad++; $display("FAIL reset_chars: got %h want 0123", chars());
    end
    total++;
    if (pos !== 4'd0) begin
      bad++; $display("FAIL reset_pos: got %0d want 0", pos);
    end
    reset = 1'b0;
    step(5);
    total++;
    if (pos !== 4'd0 || chars() !== 16'h0123) begin
      bad++; $display("FAIL idle_no_advance: pos=%0d chars=%h want pos=0 chars=0123", pos, chars());
    end
  endtask

  // 2: bouncy press then long hold gives one step; bouncy release gives none.
  task automatic test_debounce();
    int changes;
    logic [3:0] prev;
    for (int i = 0; i < 4; i++) begin
      step_btn = ~i[0];
      step(3);
    end
    total++;
    if (pos !== 4'd0) begin
      bad++; $display("FAIL bounce_press: pos=%0d want 0", pos);
    end
    step_btn = 1'b1;
    changes = 0;
    prev = pos;
    for (int i = 0; i < 50; i++) begin
      step(1);
      if (pos !== prev) changes++;
      prev = pos;
    end
    total++;
    if (changes !== 1 || pos !== 4'd1) begin
      bad++; $display("FAIL hold_one_step: changes=%0d pos=%0d want 1 and 1", changes, pos);
    end
    total++;
    if (chars() !== 16'h1234) begin
      bad++; $display("FAIL hold_chars: got %h want 1234", chars());
    end
    step_btn = 1'b0; step(3);
    step_btn = 1'b1; step(3);
    step_btn = 1'b0; step(3);
    step_btn = 1'b1; step(2);
    step_btn = 1'b0; step(30);
    total++;
    if (pos !== 4'd1 || chars() !== 16'h1234) begin
      bad++; $display("FAIL bounce_release: pos=%0d chars=%h want 1 and 1234", pos, chars());
    end
  endtask

  // 3: timed scrolling, 4-cycle tick spacing, wrap 15 -> 0.
  task automatic test_auto_scroll();
    logic [3:0] exp_pos;
    do_reset();
    auto_en = 1'b1;
    for (int i = 1; i <= 52; i++) begin
      step(1);
      exp_pos = 4'(i / 4);
      total++;
      if (pos !== exp_pos) begin
        bad++; $display("FAIL tick_spacing cyc%0d: pos=%0d want %0d", i, pos, exp_pos);
      end
    end
    auto_en = 1'b0;
    step(1);
    total++;
    if (pos !== 4'd13 || chars() !== 16'hCCC0) begin
      bad++; $display("FAIL scroll_13: pos=%0d chars=%h want 13 and ccc0", pos, chars());
    end
    auto_en = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      step(1);
      exp_pos = 4'(13 + i / 4);
      total++;
      if (pos !== exp_pos) begin
        bad++; $display("FAIL wrap_spacing cyc%0d: pos=%0d want %0d", i, pos, exp_pos);
      end
    end
    auto_en = 1'b0;
    step(1);
    total++;
    if (pos !== 4'd0 || chars() !== 16'h0123) begin
      bad++; $display("FAIL scroll_wrap: pos=%0d chars=%h want 0 and 0123", pos, chars());
    end
  endtask

  // 4: message writes, visible two edges later only inside the window.
  task automatic test_load();
    do_reset();
    load_en = 1'b1; load_addr = 4'd2; load_data = 4'd10;
    step(1);
    load_en = 1'b0;
    total++;
    if (chars() !== 16'h0123) begin
      bad++; $display("FAIL load_early: got %h want 0123", chars());
    end
    step(1);
    total++;
    if (chars() !== 16'h01A3) begin
      bad++; $display("FAIL load_visible: got %h want 01a3", chars());
    end
    load_en = 1'b1; load_addr = 4'd7; load_data = 4'd5;
    step(1);
    load_en = 1'b0;
    step(1);
    total++;
    if (chars() !== 16'h01A3) begin
      bad++; $display("FAIL load_outside: got %h want 01a3", chars());
    end
    load_en = 1'b1; load_addr = 4'd3; load_data = 4'd15;
    step(1);
    load_en = 1'b0;
    step(1);
    total++;
    if (chars() !== 16'h01AF || pos !== 4'd0) begin
      bad++; $display("FAIL load_code15: chars=%h pos=%0d want 01af and 0", chars(), pos);
    end
  endtask

  // 5: step_pulse and tick land on the same edge (11th) -> single +1.
  task automatic test_coincident();
    do_reset();
    step_btn = 1'b1;
    step(7);
    auto_en = 1'b1;
    step(3);
    total++;
    if (pos !== 4'd0) begin
      bad++; $display("FAIL coincide_early: pos=%0d want 0", pos);
    end
    step(1);
    auto_en = 1'b0;
    total++;
    if (pos !== 4'd1 || chars() !== 16'h0123) begin
      bad++; $display("FAIL coincide_pos: pos=%0d chars=%h want 1 and 0123", pos, chars());
    end
    step(1);
    total++;
    if (chars() !== 16'h1234) begin
      bad++; $display("FAIL coincide_chars: got %h want 1234", chars());
    end
    step_btn = 1'b0;
    step(20);
    total++;
    if (pos !== 4'd1) begin
      bad++; $display("FAIL coincide_after: pos=%0d want 1", pos);
    end
  endtask

  // 6: reset mid-scroll with a press in progress and a concurrent write.
  task automatic test_reset_mid();
    do_reset();
    auto_en = 1'b1;
    step(36);
    auto_en = 1'b0;
    load_en = 1'b1; load_addr = 4'd0; load_data = 4'd11;
    step(1);
    load_en = 1'b0;
    total++;
    if (pos !== 4'd9 || chars() !== 16'h9ABC) begin
      bad++; $display("FAIL pre_reset: pos=%0d chars=%h want 9 and 9abc", pos, chars());
    end
    step_btn = 1'b1;
    step(5);
    reset = 1'b1; step_btn = 1'b0;
    load_en = 1'b1; load_addr = 4'd0; load_data = 4'd11;
    step(1);
    total++;
    if (pos !== 4'd0 || chars() !== 16'h0123) begin
      bad++; $display("FAIL mid_reset: pos=%0d chars=%h want 0 and 0123", pos, chars());
    end
    reset = 1'b0; load_en = 1'b0;
    step(30);
    total++;
    if (pos !== 4'd0 || chars() !== 16'h0123) begin
      bad++; $display("FAIL post_reset: pos=%0d chars=%h want 0 and 0123", pos, chars());
    end
  endtask

  initial begin
    reset = 1'b1; step_btn = 1'b0; auto_en = 1'b0;
    load_en = 1'b0; load_addr = 4'd0; load_data = 4'd0;
    test_reset();
    test_debounce();
    test_auto_scroll();
    test_load();
    test_coincident();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
